fb_port_scheduler: RTL and testbench

Shares one single-port frame-buffer BRAM between the SD-card write stream (one 16-bit word per `wr_en` strobe) and the display read requester. Display reads normally win; SD writes are held in a small FIFO and drained into free RAM slots. When the FIFO is full, the pending write wins so no SD data is lost. The block owns both linear address counters, which wrap at one frame, and flags frame completion on the write side.

---
 rtl/fb_port_scheduler.sv | 154 +++++++++++++++
 tb/tb_fb_port_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_scheduler.sv
// fb_port_scheduler
// Arbitrates a single-port frame-buffer RAM between an SD-card write stream
// and a display read requester. Display reads win by default; SD words wait
// in a small FIFO and drain into slots the display leaves idle. A full FIFO
// takes the slot so no SD word is ever lost. Owns the linear write and read
// address counters, both wrapping at one frame.
//
// Ports:
//   clk_ref    - single clock
//   rst        - synchronous active-high reset
//   wr_en      - SD word strobe, always accepted
//   wr_data    - SD word
//   rd_req     - display asks for the next word
//   rd_ack     - combinational: rd_req accepted this cycle
//   rd_data    - read word (RAM output passed through)
//   rd_valid   - rd_data valid this cycle, two cycles after rd_ack
//   ram_en     - RAM access enable (registered)
//   ram_we     - RAM write enable (registered)
//   ram_addr   - RAM address (registered)
//   ram_wdata  - RAM write data (registered)
//   ram_rdata  - RAM read data, one cycle after the read access
//   frame_done - one-cycle pulse with the write of the last frame address
//   fifo_level - current write FIFO occupancy
module fb_port_scheduler #(
    parameter int FRAME_WORDS = 153600,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk_ref,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              rd_req,
    output logic                              rd_ack,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_valid,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_wdata,
    input  logic [DATA_W-1:0]                 ram_rdata,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    // Write FIFO: small register file with wrapping pointers (depth is a
    // power of two, so the pointers wrap on their own).
    logic [DATA_W-1:0] fifo_mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  push_ptr_reg;
    logic [PTR_W-1:0]  pop_ptr_reg;
    logic [LVL_W-1:0]  level_reg;

    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [1:0]        rd_pipe_reg;

    logic              ram_en_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              frame_done_reg;

    logic              full;
    logic              push;
    logic              do_wr;
    logic [DATA_W-1:0] head;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [ADDR_W-1:0] rd_addr_next;

    // Slot decision. A full FIFO blocks the read so the pending write takes
    // the slot; this is what guarantees a push at full always pairs with a pop.
    assign full   = (level_reg == LVL_W'(FIFO_DEPTH));
    assign rd_ack = rd_req & ~full & ~rst;
    assign do_wr  = (level_reg != '0) & ~rd_ack & ~rst;
    assign push   = wr_en & ~rst;
    assign head   = fifo_mem_reg[pop_ptr_reg];

    assign wr_addr_next = (wr_addr_reg == LAST_ADDR) ? '0 : wr_addr_reg + ADDR_W'(1);
    assign rd_addr_next = (rd_addr_reg == LAST_ADDR) ? '0 : rd_addr_reg + ADDR_W'(1);

    // FIFO storage carries no reset: contents are discarded by clearing the
    // pointers and level, never by zeroing entries.
    always_ff @(posedge clk_ref) begin
        if (push) begin
            fifo_mem_reg[push_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            push_ptr_reg   <= '0;
            pop_ptr_reg    <= '0;
            level_reg      <= '0;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            rd_pipe_reg    <= '0;
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push) begin
                push_ptr_reg <= push_ptr_reg + PTR_W'(1);
            end
            if (do_wr) begin
                pop_ptr_reg <= pop_ptr_reg + PTR_W'(1);
            end
            case ({push, do_wr})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase

            // Stage 0 marks the RAM access cycle, stage 1 the data cycle.
            rd_pipe_reg <= {rd_pipe_reg[0], rd_ack};

            if (rd_ack) begin
                ram_en_reg     <= 1'b1;
                ram_we_reg     <= 1'b0;
                ram_addr_reg   <= rd_addr_reg;
                rd_addr_reg    <= rd_addr_next;
                frame_done_reg <= 1'b0;
            end else if (do_wr) begin
                ram_en_reg     <= 1'b1;
                ram_we_reg     <= 1'b1;
                ram_addr_reg   <= wr_addr_reg;
                ram_wdata_reg  <= head;
                wr_addr_reg    <= wr_addr_next;
                frame_done_reg <= (wr_addr_reg == LAST_ADDR);
            end else begin
                // Idle slot: address and data hold to avoid needless toggling.
                ram_en_reg     <= 1'b0;
                ram_we_reg     <= 1'b0;
                frame_done_reg <= 1'b0;
            end
        end
    end

    assign rd_data    = ram_rdata;
    assign rd_valid   = rd_pipe_reg[1];
    assign ram_en     = ram_en_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign frame_done = frame_done_reg;
    assign fifo_level = level_reg;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Testbench for fb_port_scheduler with an 8-word frame. A behavioural RAM
// sits on the RAM port. Expected writes (address, data) and expected read
// words are queued by the stimulus; a negedge monitor pops and compares
// whenever the DUT issues a write or presents rd_valid.
module tb_fb_port_scheduler;

    localparam int FW = 8;

    logic        clk_ref = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        ram_en;
    logic        ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        frame_done;
    logic [2:0]  fifo_level;

    fb_port_scheduler #(
        .FRAME_WORDS(FW),
        .ADDR_W     (18),
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_ref   (clk_ref),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .frame_done(frame_done),
        .fifo_level(fifo_level)
    );

    always #5 clk_ref = ~clk_ref;

    // Behavioural single-port RAM with registered read.
    logic [15:0] mem [0:FW-1];
    always @(posedge clk_ref) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[2:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[2:0]];
        end
    end

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    wr_exp_t     wr_q [$];
    logic [15:0] rd_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    int first_we_cyc = -1;
    int we_count = 0;
    int fd_count = 0;
    int max_level = 0;
    logic [17:0] exp_wr_addr = '0;

    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic push_wr_exp(input logic [15:0] d);
        wr_exp_t e;
        e.addr = exp_wr_addr;
        e.data = d;
        wr_q.push_back(e);
        exp_wr_addr = (exp_wr_addr == 18'(FW - 1)) ? '0 : exp_wr_addr + 18'd1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk_ref) begin
        if (mon_en) begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (frame_done === 1'b1) fd_count++;
            if (ram_en === 1'b1 && ram_we === 1'b1) begin
                wr_exp_t e;
                we_count++;
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_wdata);
                end else begin
                    e = wr_q.pop_front();
                    $display("WR addr=%0d data=0x%04h frame_done=%0b", ram_addr, ram_wdata, frame_done);
                    chk("wr_addr", 32'(ram_addr), 32'(e.addr));
                    chk("wr_data", 32'(ram_wdata), 32'(e.data));
                    chk("frame_done_on_write", 32'(frame_done), 32'(e.addr == 18'(FW - 1)));
                end
            end else begin
                chk("frame_done_no_write", 32'(frame_done), 32'd0);
            end
            if (rd_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_read: got rd_valid with data 0x%0h, required none", rd_data);
                end else begin
                    logic [15:0] d;
                    d = rd_q.pop_front();
                    $display("RD data=0x%04h", rd_data);
                    chk("rd_data", 32'(rd_data), 32'(d));
                end
            end
        end
    end

    // Expected per-cycle rd_ack / fifo_level while rd_req is held high and
    // wr_en strobes for 8 cycles.
    logic [11:0] ack_tab;
    int          lvl_tab [12];

    initial begin
        ack_tab = 12'b1110_0000_1111; // bit i = cycle i
        lvl_tab = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 3, 3};

        rst = 1'b1; wr_en = 1'b1; wr_data = 16'hFFFF; rd_req = 1'b1;
        step();
        mon_en = 1;
        @(negedge clk_ref);
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        step();
        @(negedge clk_ref);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_rd_ack_held", 32'(rd_ack), 32'd0);
        step();
        rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
        exp_wr_addr = '0;

        // Five back-to-back writes, no reads.
        begin
            int s;
            first_we_cyc = -1; we_count = 0; max_level = 0;
            s = cyc;
            for (int i = 0; i < 5; i++) begin
                wr_en = 1'b1; wr_data = 16'hA000 + 16'(i);
                push_wr_exp(wr_data);
                step();
            end
            wr_en = 1'b0;
            repeat (6) step();
            chk("wr_latency", 32'(first_we_cyc - s), 32'd2);
            chk("wr_count", 32'(we_count), 32'd5);
            chk("level_peak", 32'(max_level), 32'd1);
        end

        // Fresh frame: 0x10..0x17, single read, then 8 more reads with wrap.
        rst = 1'b1; step(); rst = 1'b0; exp_wr_addr = '0;
        fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 16'h0010 + 16'(i);
            push_wr_exp(wr_data);
            step();
        end
        wr_en = 1'b0;
        repeat (4) step();

        rd_q.push_back(16'h0010);
        rd_req = 1'b1;
        @(negedge clk_ref);
        chk("single_rd_ack", 32'(rd_ack), 32'd1);
        step();
        rd_req = 1'b0;
        @(negedge clk_ref);
        chk("rd_valid_n1", 32'(rd_valid), 32'd0);
        step();
        @(negedge clk_ref);
        chk("rd_valid_n2", 32'(rd_valid), 32'd1);
        step();
        @(negedge clk_ref);
        chk("rd_valid_n3", 32'(rd_valid), 32'd0);
        step();

        for (int i = 1; i < 8; i++) rd_q.push_back(16'h0010 + 16'(i));
        rd_q.push_back(16'h0010);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_ref);
            chk("burst_rd_ack", 32'(rd_ack), 32'd1);
            step();
        end
        rd_req = 1'b0;
        repeat (4) step();

        // Two more writes: wrap to address 0, no second frame_done.
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 16'h0018 + 16'(i);
            push_wr_exp(wr_data);
            step();
        end
        wr_en = 1'b0;
        repeat (4) step();
        chk("frame_done_count", 32'(fd_count), 32'd1);

        // Reads held high while writes strobe every cycle: FIFO fills,
        // full cycles steal read slots.
        rd_q.push_back(16'h0019);
        rd_q.push_back(16'h0012);
        rd_q.push_back(16'h0013);
        rd_q.push_back(16'h0014);
        rd_q.push_back(16'h0043);
        rd_q.push_back(16'h0044);
        rd_q.push_back(16'h0017);
        rd_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_en = (i < 8);
            wr_data = 16'h0040 + 16'(i);
            if (i < 8) push_wr_exp(wr_data);
            @(negedge clk_ref);
            chk($sformatf("contend_rd_ack_c%0d", i), 32'(rd_ack), 32'(ack_tab[i]));
            chk($sformatf("contend_level_c%0d", i), 32'(fifo_level), 32'(lvl_tab[i]));
            step();
        end
        rd_req = 1'b0; wr_en = 1'b0;
        repeat (6) step();

        // Reset mid-stream: level 3, two reads in flight.
        rd_q.push_back(16'h0046);
        rd_q.push_back(16'h0047);
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'h0050 + 16'(i);
            @(negedge clk_ref);
            chk("pre_rst_rd_ack", 32'(rd_ack), 32'd1);
            step();
        end
        rst = 1'b1;
        @(negedge clk_ref);
        chk("mid_rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("mid_rst_level_before", 32'(fifo_level), 32'd3);
        step();
        rst = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
        exp_wr_addr = '0;
        @(negedge clk_ref);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("post_rst_ram_en", 32'(ram_en), 32'd0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        step();

        wr_en = 1'b1; wr_data = 16'h0060;
        push_wr_exp(wr_data);
        step();
        wr_en = 1'b0;
        repeat (4) step();
        rd_q.push_back(16'h0060);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        repeat (4) step();

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
